// File: rtl/alu.sv
// rtl/alu.sv - 64-bit LEGv8 combinational ALU with registered NZCV flag capture
module alu #(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic [3:0]      alu_control,
    input  logic            set_flags,
    output logic [WORD-1:0] result,
    output logic            zero,
    output logic            negative,
    output logic            carry,
    output logic            overflow,
    output logic [3:0]      nzcv_q
);

    localparam int SHW = $clog2(WORD);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_ORR  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_EOR  = 4'b0011,
        OP_LSL  = 4'b0100,
        OP_LSR  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_PASS = 4'b0111,
        OP_NOR  = 4'b1100
    } op_t;

    logic            is_sub;
    logic [WORD-1:0] b_op;
    logic [WORD:0]   sum;
    logic [SHW-1:0]  shamt;

    // One shared adder serves ADD and SUB; SUB is a + ~b + 1.
    assign is_sub = (alu_control == OP_SUB);
    assign b_op   = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_op} + {{WORD{1'b0}}, is_sub};
    assign shamt  = b[SHW-1:0];

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_control)
            OP_AND:  result = a & b;
            OP_ORR:  result = a | b;
            OP_EOR:  result = a ^ b;
            OP_LSL:  result = a << shamt;
            OP_LSR:  result = a >> shamt;
            OP_PASS: result = b;
            OP_NOR:  result = ~(a | b);
            OP_ADD, OP_SUB: begin
                result   = sum[WORD-1:0];
                carry    = sum[WORD];
                // b_op already carries the inverted sign for SUB, so one rule covers both.
                overflow = (a[WORD-1] == b_op[WORD-1]) && (sum[WORD-1] != a[WORD-1]);
            end
            default: result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[WORD-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nzcv_q <= 4'b0000;
        end else if (set_flags) begin
            nzcv_q <= {negative, zero, carry, overflow};
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu against a plain-arithmetic reference model
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [3:0]  alu_control = '0;
    logic        set_flags = 1'b0;
    logic [63:0] result;
    logic        zero, negative, carry, overflow;
    logic [3:0]  nzcv_q;

    alu #(.WORD(64)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_control(alu_control),
        .set_flags(set_flags), .result(result), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .nzcv_q(nzcv_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r;
        logic        n, z, c, v;
        logic [3:0]  q;
        logic [3:0]  op;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic       prev_rst = 1'b0;
    logic       prev_set = 1'b0;
    logic [3:0] prev_flags = 4'b0000;
    logic [3:0] model_q = 4'b0000;

    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic [3:0] op);
        exp_t e;
        logic signed [65:0] sx, sy, st;
        sx = $signed(x);
        sy = $signed(y);
        e.r = '0; e.c = 1'b0; e.v = 1'b0; e.q = '0; e.op = op;
        case (op)
            4'd0:  e.r = x & y;
            4'd1:  e.r = x | y;
            4'd2: begin
                e.r = x + y;
                e.c = ({1'b0, x} + {1'b0, y}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
                st  = sx + sy;
                e.v = (st > SMAX) || (st < SMIN);
            end
            4'd3:  e.r = x ^ y;
            4'd4:  e.r = x << y[5:0];
            4'd5:  e.r = x >> y[5:0];
            4'd6: begin
                e.r = x - y;
                e.c = (x >= y);
                st  = sx - sy;
                e.v = (st > SMAX) || (st < SMIN);
            end
            4'd7:  e.r = y;
            4'd12: e.r = ~(x | y);
            default: e.r = '0;
        endcase
        e.n = e.r[63];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic [3:0] op,
                         input logic sf, input logic rn);
        exp_t e;
        @(posedge clk);
        #2;
        if (!prev_rst) model_q = 4'b0000;
        else if (prev_set) model_q = prev_flags;
        a = x; b = y; alu_control = op; set_flags = sf; rst_n = rn;
        e = model(x, y, op);
        e.q = model_q;
        sbq.push_back(e);
        prev_rst = rn;
        prev_set = sf;
        prev_flags = {e.n, e.z, e.c, e.v};
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if ({result, negative, zero, carry, overflow} !== {e.r, e.n, e.z, e.c, e.v}) begin
                errors++;
                $display("FAIL comb op=%h a=%h b=%h got r=%h nzcv=%b%b%b%b want r=%h nzcv=%b%b%b%b",
                         e.op, a, b, result, negative, zero, carry, overflow,
                         e.r, e.n, e.z, e.c, e.v);
            end
            checks++;
            if (nzcv_q !== e.q) begin
                errors++;
                $display("FAIL nzcv_q got %b want %b", nzcv_q, e.q);
            end
        end
    end

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'(unsigned'($urandom_range(0, 70)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [3:0] codes [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12};

    initial begin
        // Reset held with set_flags high: reset must win.
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd2, 1'b1, 1'b0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd2, 1'b1, 1'b0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd2, 1'b1, 1'b1);
        issue(64'h7FFF_FFFF_FFFF_FFFE, 64'h1, 4'd2, 1'b0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'h1, 4'd6, 1'b1, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 1'b0, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FFFD, 64'h3, 4'd2, 1'b1, 1'b1);
        issue(64'h0, 64'h0, 4'd0, 1'b0, 1'b1);
        issue(64'h0, 64'h0, 4'd0, 1'b0, 1'b0);
        issue(64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1, 1'b1);
        issue(64'h1, 64'd63, 4'd4, 1'b1, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'd63, 4'd5, 1'b0, 1'b1);
        issue(64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFC0, 4'd4, 1'b0, 1'b1);
        issue(64'h0, 64'h0, 4'd12, 1'b1, 1'b1);
        issue(64'h5, 64'h0, 4'd7, 1'b1, 1'b1);
        issue(64'hDEAD_BEEF_0000_0001, 64'h1, 4'd9, 1'b1, 1'b1);
        issue(64'h0, 64'h0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 8)];
            issue(pick_operand(), pick_operand(), op, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) != 0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
